ahb_mem_arbiter: RTL

AHB_MEM_ARBITER -- requirements
Module: ahb_mem_arbiter

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_wait_timer.sv | 38 +++
 rtl/ahb_mem_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and master FSM state codes
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   // Sizes wider than a word are not supported by the memory path.
   function automatic logic [2:0] clamp_hsize(input logic [2:0] size);
      return (size > HSIZE_WORD) ? HSIZE_WORD : size;
   endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// rtl/ahb_wait_timer.sv - data-phase wait-state counter with saturating expiry flag
module ahb_wait_timer #(
   parameter int TMO_CYC = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturate at the limit so expired stays high until the next clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ahb_mem_arbiter.sv
// rtl/ahb_mem_arbiter.sv - fetch/data arbiter driving one AHB-Lite master port,
// data side has fixed priority; completions are registered one-cycle pulses.
module ahb_mem_arbiter
   import ahb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              bus_err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [2:0]        size_q, size_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic              bus_err_q, bus_err_d;
   logic              xfer_end, xfer_fail;
   logic              timer_clear, timer_enable, timer_expired;

   assign timer_clear  = (state_q == ST_ADDR) && HREADY;
   assign timer_enable = (state_q == ST_DATA) && !HREADY;

   ahb_wait_timer #(.TMO_CYC(TMO_CYC)) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_done_d  = 1'b0;
      d_done_d   = 1'b0;
      bus_err_d  = 1'b0;
      xfer_end   = 1'b0;
      xfer_fail  = 1'b0;

      case (state_q)
         // A requester whose done is pulsing still holds its req this cycle; skip it.
         ST_IDLE: begin
            if (d_req && !d_done_q) begin
               owner_d = 1'b1;
               addr_d  = d_addr;
               we_d    = d_we;
               size_d  = clamp_hsize(d_size);
               wdata_d = d_wdata;
               state_d = ST_ADDR;
            end else if (if_req && !if_done_q) begin
               owner_d = 1'b0;
               addr_d  = if_addr;
               we_d    = 1'b0;
               size_d  = HSIZE_WORD;
               wdata_d = '0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (timer_expired) begin
               xfer_end  = 1'b1;
               xfer_fail = 1'b1;
            end else if (HRESP == HRESP_ERROR) begin
               if (HREADY) begin
                  xfer_end  = 1'b1;
                  xfer_fail = 1'b1;
               end else begin
                  state_d = ST_ERR;
               end
            end else if (HREADY) begin
               xfer_end = 1'b1;
            end
         end
         ST_ERR: begin
            if (HREADY) begin
               xfer_end  = 1'b1;
               xfer_fail = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (xfer_end) begin
         state_d   = ST_IDLE;
         bus_err_d = xfer_fail;
         if (owner_q) d_done_d  = 1'b1;
         else         if_done_d = 1'b1;
         if (!xfer_fail && !we_q) begin
            if (owner_q) d_rdata_d  = HRDATA;
            else         if_rdata_d = HRDATA;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         size_q     <= HSIZE_WORD;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_done_q  <= if_done_d;
         d_done_q   <= d_done_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign HTRANS   = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HBURST   = HBURST_SINGLE;
   assign HADDR    = addr_q;
   assign HWRITE   = we_q;
   assign HSIZE    = size_q;
   assign HWDATA   = wdata_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign if_done  = if_done_q;
   assign d_done   = d_done_q;
   assign bus_err  = bus_err_q;

endmodule
